// File: rtl/core_types_pkg.sv
// Core-wide type and sizing package; holds the return-address-stack geometry
// and the count saturation helper shared by the fetch block and the RAS.
package core_types_pkg;

    localparam int unsigned RAS_ENTRIES      = 8;
    localparam int unsigned RAS_TARGET_WIDTH = 31;
    localparam int unsigned LOG_RAS_ENTRIES  = $clog2(RAS_ENTRIES);
    localparam int unsigned RAS_COUNT_WIDTH  = LOG_RAS_ENTRIES + 1;

    typedef logic [RAS_TARGET_WIDTH-1:0] ras_target_t;
    typedef logic [LOG_RAS_ENTRIES-1:0]  ras_ptr_t;
    typedef logic [RAS_COUNT_WIDTH-1:0]  ras_cnt_t;

    localparam ras_cnt_t RAS_FULL_COUNT = RAS_COUNT_WIDTH'(RAS_ENTRIES);

    // Clamp a checkpointed count to the physical stack depth.
    function automatic ras_cnt_t ras_sat_count(input ras_cnt_t cnt);
        return (cnt > RAS_FULL_COUNT) ? RAS_FULL_COUNT : cnt;
    endfunction

endpackage

// File: rtl/ras.sv
// Circular return-address stack with checkpoint restore for mispredicts.
// Optional macro RAS_UNDERFLOW_PROTECT_EN freezes the pointer on a pop from an empty stack.
module ras
    import core_types_pkg::*;
(
    input  logic                        CLK,
    input  logic                        nRST,
    input  logic                        link_valid,
    input  logic [RAS_TARGET_WIDTH-1:0] link_pc,
    input  logic                        ret_valid,
    output logic [RAS_TARGET_WIDTH-1:0] ret_pc,
    output logic [LOG_RAS_ENTRIES-1:0]  ras_index,
    output logic [RAS_COUNT_WIDTH-1:0]  ras_count,
    output logic                        ras_empty,
    input  logic                        update_valid,
    input  logic [LOG_RAS_ENTRIES-1:0]  update_ras_index,
    input  logic [RAS_COUNT_WIDTH-1:0]  update_ras_count
);

    ras_target_t stack_q [RAS_ENTRIES];
    ras_ptr_t    ras_index_q;
    ras_cnt_t    ras_count_q;

    ras_ptr_t    idx_inc;
    ras_ptr_t    idx_dec;
    ras_ptr_t    idx_d;
    ras_cnt_t    cnt_d;
    ras_ptr_t    wr_ptr;
    logic        wr_en;

    // Pointer width equals log2(depth), so plain add/sub wraps modulo depth.
    assign idx_inc = ras_index_q + LOG_RAS_ENTRIES'(1);
    assign idx_dec = ras_index_q - LOG_RAS_ENTRIES'(1);

    // Next pointer/count and write-port selection; restore beats push/pop.
    always_comb begin
        wr_en  = 1'b0;
        wr_ptr = ras_index_q;
        idx_d  = ras_index_q;
        cnt_d  = ras_count_q;

        if (update_valid) begin
            idx_d = update_ras_index;
            cnt_d = ras_sat_count(update_ras_count);
        end else if (link_valid && ret_valid) begin
            wr_en  = 1'b1;
            wr_ptr = ras_index_q;
            if (ras_count_q == '0) begin
                cnt_d = RAS_COUNT_WIDTH'(1);
            end
        end else if (link_valid) begin
            // When full, idx_inc lands on the oldest entry and overwrites it.
            wr_en  = 1'b1;
            wr_ptr = idx_inc;
            idx_d  = idx_inc;
            if (ras_count_q != RAS_FULL_COUNT) begin
                cnt_d = ras_count_q + RAS_COUNT_WIDTH'(1);
            end
        end else if (ret_valid) begin
            if (ras_count_q != '0) begin
                idx_d = idx_dec;
                cnt_d = ras_count_q - RAS_COUNT_WIDTH'(1);
            end else begin
`ifdef RAS_UNDERFLOW_PROTECT_EN
                idx_d = ras_index_q;
`else
                idx_d = idx_dec;
`endif
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            ras_index_q <= '0;
            ras_count_q <= '0;
        end else begin
            ras_index_q <= idx_d;
            ras_count_q <= cnt_d;
        end
    end

    // Single-write-port flop array.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < int'(RAS_ENTRIES); i++) begin
                stack_q[i] <= '0;
            end
        end else if (wr_en) begin
            stack_q[wr_ptr] <= link_pc;
        end
    end

    assign ret_pc    = stack_q[ras_index_q];
    assign ras_index = ras_index_q;
    assign ras_count = ras_count_q;
    assign ras_empty = (ras_count_q == '0);

endmodule

// File: tb/tb_ras.sv
// Self-checking bench for ras: directed scenarios plus randomized traffic
// checked against an array/integer model of the stack rules.
module tb_ras;
    import core_types_pkg::*;

    localparam int N = int'(RAS_ENTRIES);

    logic                        CLK;
    logic                        nRST;
    logic                        link_valid;
    logic [RAS_TARGET_WIDTH-1:0] link_pc;
    logic                        ret_valid;
    logic [RAS_TARGET_WIDTH-1:0] ret_pc;
    logic [LOG_RAS_ENTRIES-1:0]  ras_index;
    logic [RAS_COUNT_WIDTH-1:0]  ras_count;
    logic                        ras_empty;
    logic                        update_valid;
    logic [LOG_RAS_ENTRIES-1:0]  update_ras_index;
    logic [RAS_COUNT_WIDTH-1:0]  update_ras_count;

    int checks = 0;
    int errors = 0;

    // Reference model: plain integers and an array of return addresses.
    int          m_idx;
    int          m_cnt;
    bit [31:0]   m_mem [N];

    ras dut (
        .CLK              (CLK),
        .nRST             (nRST),
        .link_valid       (link_valid),
        .link_pc          (link_pc),
        .ret_valid        (ret_valid),
        .ret_pc           (ret_pc),
        .ras_index        (ras_index),
        .ras_count        (ras_count),
        .ras_empty        (ras_empty),
        .update_valid     (update_valid),
        .update_ras_index (update_ras_index),
        .update_ras_count (update_ras_count)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        m_idx = 0;
        m_cnt = 0;
        for (int i = 0; i < N; i++) m_mem[i] = '0;
    endfunction

    function automatic void model_step(input bit lv, input bit [31:0] lpc, input bit rv,
                                       input bit uv, input int ui, input int uc);
        if (uv) begin
            m_idx = ui;
            m_cnt = (uc > N) ? N : uc;
        end else if (lv && rv) begin
            m_mem[m_idx] = lpc;
            if (m_cnt < 1) m_cnt = 1;
        end else if (lv) begin
            m_idx = (m_idx + 1) % N;
            m_mem[m_idx] = lpc;
            if (m_cnt < N) m_cnt = m_cnt + 1;
        end else if (rv) begin
            if (m_cnt > 0) begin
                m_idx = (m_idx + N - 1) % N;
                m_cnt = m_cnt - 1;
            end else begin
`ifndef RAS_UNDERFLOW_PROTECT_EN
                m_idx = (m_idx + N - 1) % N;
`endif
            end
        end
    endfunction

    task automatic check_state(input string tag);
        check({tag, "_ret_pc"}, 32'(ret_pc), m_mem[m_idx]);
        check({tag, "_index"},  32'(ras_index), 32'(m_idx));
        check({tag, "_count"},  32'(ras_count), 32'(m_cnt));
        check({tag, "_empty"},  32'(ras_empty), 32'(m_cnt == 0));
    endtask

    // One clock of stimulus: ret_pc checked before the edge, full state after.
    task automatic step(input string tag, input bit lv, input bit [31:0] lpc, input bit rv,
                        input bit uv, input int ui, input int uc);
        @(negedge CLK);
        link_valid       = lv;
        link_pc          = RAS_TARGET_WIDTH'(lpc);
        ret_valid        = rv;
        update_valid     = uv;
        update_ras_index = LOG_RAS_ENTRIES'(ui);
        update_ras_count = RAS_COUNT_WIDTH'(uc);
        #1;
        check({tag, "_pre_ret_pc"}, 32'(ret_pc), m_mem[m_idx]);
        @(posedge CLK);
        model_step(lv, 32'(RAS_TARGET_WIDTH'(lpc)), rv, uv, ui, uc);
        #1;
        link_valid   = 1'b0;
        ret_valid    = 1'b0;
        update_valid = 1'b0;
        check_state(tag);
    endtask

    // Reset asserted mid-cycle alongside a push of 0x3FF.
    task automatic do_reset(input string tag);
        @(negedge CLK);
        link_valid = 1'b1;
        link_pc    = RAS_TARGET_WIDTH'(32'h3FF);
        ret_valid  = 1'b0;
        nRST       = 1'b0;
        #1;
        model_reset();
        check({tag, "_rst_ret_pc"}, 32'(ret_pc), 32'h0);
        check({tag, "_rst_index"},  32'(ras_index), 32'h0);
        check({tag, "_rst_count"},  32'(ras_count), 32'h0);
        check({tag, "_rst_empty"},  32'(ras_empty), 32'h1);
        repeat (2) @(posedge CLK);
        #1;
        check({tag, "_rst_hold_count"}, 32'(ras_count), 32'h0);
        @(negedge CLK);
        link_valid = 1'b0;
        nRST       = 1'b1;
    endtask

    initial begin
        nRST             = 1'b0;
        link_valid       = 1'b0;
        link_pc          = '0;
        ret_valid        = 1'b0;
        update_valid     = 1'b0;
        update_ras_index = '0;
        update_ras_count = '0;
        model_reset();

        do_reset("init");

        // Basic push/pop ordering.
        step("p100", 1, 32'h100, 0, 0, 0, 0);
        step("p200", 1, 32'h200, 0, 0, 0, 0);
        step("p300", 1, 32'h300, 0, 0, 0, 0);
        check("seq_top", 32'(ret_pc), 32'h300);
        check("seq_idx", 32'(ras_index), 32'd3);
        check("seq_cnt", 32'(ras_count), 32'd3);
        step("pop1", 0, 0, 1, 0, 0, 0);
        check("seq_pop_top", 32'(ret_pc), 32'h200);
        check("seq_pop_cnt", 32'(ras_count), 32'd2);

        // Overflow wraps and drops the oldest entry.
        do_reset("ovf");
        for (int v = 1; v <= 9; v++) step("ovf_push", 1, 32'(v), 0, 0, 0, 0);
        check("ovf_cnt", 32'(ras_count), 32'd8);
        check("ovf_idx", 32'(ras_index), 32'd1);
        check("ovf_top", 32'(ret_pc), 32'h9);
        for (int v = 9; v >= 2; v--) begin
            check("ovf_pop_val", 32'(ret_pc), 32'(v));
            step("ovf_pop", 0, 0, 1, 0, 0, 0);
        end
        check("ovf_empty", 32'(ras_empty), 32'd1);

        // Simultaneous push and pop replaces the top.
        do_reset("rep");
        step("rep_a", 1, 32'h100, 0, 0, 0, 0);
        step("rep_b", 1, 32'h200, 0, 0, 0, 0);
        step("rep_pp", 1, 32'h500, 1, 0, 0, 0);
        check("rep_top", 32'(ret_pc), 32'h500);
        check("rep_cnt", 32'(ras_count), 32'd2);
        check("rep_idx", 32'(ras_index), 32'd2);

        // Checkpoint restore wins over a same-cycle push.
        do_reset("ckp");
        step("ckp_a", 1, 32'h100, 0, 0, 0, 0);
        step("ckp_b", 1, 32'h200, 0, 0, 0, 0);
        step("ckp_c", 1, 32'hA, 0, 0, 0, 0);
        step("ckp_d", 1, 32'hB, 0, 0, 0, 0);
        step("ckp_upd", 1, 32'hC, 0, 1, 2, 2);
        check("ckp_idx", 32'(ras_index), 32'd2);
        check("ckp_cnt", 32'(ras_count), 32'd2);
        check("ckp_top", 32'(ret_pc), 32'h200);
        step("ckp_peek3", 0, 0, 0, 1, 3, 3);
        check("ckp_e3", 32'(ret_pc), 32'hA);
        step("ckp_peek4", 0, 0, 0, 1, 4, 15);
        check("ckp_e4", 32'(ret_pc), 32'hB);
        check("ckp_sat", 32'(ras_count), 32'd8);

        // Pop from empty stack.
        do_reset("und");
        step("und_pop", 0, 0, 1, 0, 0, 0);
        check("und_cnt", 32'(ras_count), 32'd0);
`ifdef RAS_UNDERFLOW_PROTECT_EN
        check("und_idx", 32'(ras_index), 32'd0);
`else
        check("und_idx", 32'(ras_index), 32'd7);
`endif

        // Reset concurrent with a push leaves no trace of the pushed value.
        step("rst_pre", 1, 32'h123, 0, 0, 0, 0);
        do_reset("rstp");
        for (int i = 0; i < N; i++) begin
            step("rst_scan", 0, 0, 0, 1, i, 1);
            check("rst_scan_entry", 32'(ret_pc), 32'h0);
        end

        // Randomized traffic, with occasional mid-stream resets.
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset("rnd");
            end else begin
                step("rnd",
                     1'($urandom_range(0, 1)),
                     $urandom,
                     1'($urandom_range(0, 1)),
                     ($urandom_range(0, 9) == 0),
                     int'($urandom_range(0, N - 1)),
                     int'($urandom_range(0, 15)));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ras.md
RAS -- requirements
Module: ras

Interface
- REQ-001: The module SHALL take RAS_ENTRIES (default 8) from core_types_pkg: number of return-address stack entries, a power of two.
- REQ-002: The module SHALL take RAS_TARGET_WIDTH (default 31) from core_types_pkg: width of a stored return address, PC[31:1].
- REQ-003: CLK  input  1  single clock; all state updates on the rising edge.
- REQ-004: nRST  input  1  reset, asynchronous, active-low.
- REQ-005: link_valid  input  1  call seen in the fetch block; push link_pc.
- REQ-006: link_pc  input  RAS_TARGET_WIDTH  return address to push.
- REQ-007: ret_valid  input  1  return seen in the fetch block; pop.
- REQ-008: ret_pc  output  RAS_TARGET_WIDTH  current top-of-stack entry, combinational from state.
- REQ-009: ras_index  output  LOG_RAS_ENTRIES  current top pointer; carried by the fetch block as a checkpoint.
- REQ-010: ras_count  output  LOG_RAS_ENTRIES+1  valid entries, range 0..RAS_ENTRIES; carried as a checkpoint.
- REQ-011: ras_empty  output  1  asserted when ras_count == 0.
- REQ-012: update_valid  input  1  mispredict restore request.
- REQ-013: update_ras_index  input  LOG_RAS_ENTRIES  checkpointed pointer to restore.
- REQ-014: update_ras_count  input  LOG_RAS_ENTRIES+1  checkpointed count to restore.

Function
- REQ-015: The stack SHALL be a circular array of RAS_ENTRIES entries; ras_index SHALL address the top entry, and all pointer arithmetic SHALL wrap modulo RAS_ENTRIES.
- REQ-016: Push only SHALL write link_pc to entry ras_index+1, then set ras_index to ras_index+1 and ras_count to min(ras_count+1, RAS_ENTRIES).
- REQ-017: A push at ras_count == RAS_ENTRIES SHALL overwrite the oldest entry; ras_count SHALL stay at RAS_ENTRIES.
- REQ-018: Pop only, non-empty: ret_pc SHALL give entry ras_index in the same cycle; next cycle ras_index SHALL be ras_index-1 and ras_count SHALL be ras_count-1.
- REQ-019: Push and pop in the same cycle SHALL replace the top:
  - ret_pc gives the old entry ras_index;
  - entry ras_index is written with link_pc;
  - ras_index is unchanged;
  - ras_count becomes max(ras_count, 1).
- REQ-020: update_valid SHALL take priority over push and pop in the same cycle; the push/pop SHALL be dropped.
- REQ-021: On update_valid, ras_index and ras_count SHALL load the update values next cycle, and stack contents SHALL be unchanged.
- REQ-022: update_ras_count > RAS_ENTRIES SHALL be saturated to RAS_ENTRIES.
- REQ-023: All state changes SHALL have single-cycle latency; the new ret_pc and ras_index SHALL be visible the cycle after the event.

Reset
- REQ-024: While nRST is low, all stack entries, ras_index and ras_count SHALL be 0, ret_pc SHALL be 0, and ras_empty SHALL be 1.
- REQ-025: Reset asserted mid-operation SHALL discard any same-cycle push, pop or update.

Configuration
- REQ-026: With RAS_UNDERFLOW_PROTECT_EN defined, a pop-only at ras_count == 0 SHALL leave ras_index and ras_count unchanged, and ret_pc SHALL still present entry ras_index (stale).
- REQ-027: Without RAS_UNDERFLOW_PROTECT_EN, a pop-only at ras_count == 0 SHALL decrement ras_index with wrap, ras_count SHALL stay 0, and ret_pc SHALL present entry ras_index (stale).

Structure
- REQ-028: RAS_ENTRIES, RAS_TARGET_WIDTH and a new LOG_RAS_ENTRIES = $clog2(RAS_ENTRIES) SHALL live in core_types_pkg; no module-local copies.
- REQ-029: The block SHALL be a single module with no sub-module; the stack SHALL be a flop array with one write port and one read port.

Verification
- REQ-030: Reset, then push 0x100, 0x200, 0x300 -> ret_pc=0x300, ras_index=3, ras_count=3; pop -> ret_pc=0x300 that cycle, then ret_pc=0x200, ras_count=2.
- REQ-031: Push 9 values 0x1..0x9 from reset -> ras_count=8, ras_index=1, ret_pc=0x9; 8 pops return 0x9..0x2, then ras_empty=1.
- REQ-032: With ras_count=2 and top=0x200, push 0x500 and pop in the same cycle -> ret_pc=0x200 that cycle, then ret_pc=0x500, count=2, index unchanged.
- REQ-033: Checkpoint index=2/count=2, push 0xA, 0xB, then update_valid with (2,2) and push 0xC in the same cycle -> ras_index=2, ras_count=2, 0xC not written, ret_pc=original entry 2.
- REQ-034: From reset, pop -> with RAS_UNDERFLOW_PROTECT_EN: ras_index=0, ras_count=0; without it: ras_index=7, ras_count=0.
- REQ-035: Assert nRST low in the same cycle as a push of 0x3FF -> all outputs 0, ras_empty=1, and no entry holds 0x3FF after release.
